// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, grant owners and access sizes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // DM has priority unless IF has been passed over STARVE_MAX times in a row.
    function automatic logic pick_if(input logic if_elig, input logic dm_req, input logic starve_sat);
        return if_elig && (!dm_req || starve_sat);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/MEM stages, the arbiter and the backing memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic [31:0]       IF_RDATA;
    logic              IF_DONE;
    logic              IF_STALL;
    logic              FLUSH;

    logic              DM_REQ;
    logic              DM_WE;
    logic [1:0]        DM_SIZE;
    logic [ADDR_W-1:0] DM_ADDR;
    logic [DATA_W-1:0] DM_WDATA;
    logic [DATA_W-1:0] DM_RDATA;
    logic              DM_DONE;
    logic              DM_STALL;

    logic              M_REQ;
    logic              M_WE;
    logic [1:0]        M_SIZE;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_WDATA;
    logic [DATA_W-1:0] M_RDATA;
    logic              M_READY;

    logic              BUSY;

    // Arbiter side.
    modport master (
        input  IF_REQ, IF_ADDR, FLUSH,
        input  DM_REQ, DM_WE, DM_SIZE, DM_ADDR, DM_WDATA,
        input  M_RDATA, M_READY,
        output IF_RDATA, IF_DONE, IF_STALL,
        output DM_RDATA, DM_DONE, DM_STALL,
        output M_REQ, M_WE, M_SIZE, M_ADDR, M_WDATA,
        output BUSY
    );

    // Requester / memory side.
    modport slave (
        output IF_REQ, IF_ADDR, FLUSH,
        output DM_REQ, DM_WE, DM_SIZE, DM_ADDR, DM_WDATA,
        output M_RDATA, M_READY,
        input  IF_RDATA, IF_DONE, IF_STALL,
        input  DM_RDATA, DM_DONE, DM_STALL,
        input  M_REQ, M_WE, M_SIZE, M_ADDR, M_WDATA,
        input  BUSY
    );

endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of consecutive DM grants taken while IF is waiting.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4,
    parameter int CW         = $clog2(STARVE_MAX + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          sat
);

    assign sat = (cnt == CW'(STARVE_MAX));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM-stage load/store path,
// one access at a time through IDLE -> ISSUE -> RESP.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    mem_port_arbiter_if.master bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    state_t            state;
    state_t            state_nx;
    owner_t            owner;
    logic              if_kill;

    logic              m_we_q;
    logic [1:0]        m_size_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [31:0]       if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic              if_elig;
    logic              grant;
    logic              grant_if;
    logic              starve_inc;
    logic              starve_clr;
    logic              starve_sat;
    logic [CW-1:0]     starve_cnt;

    assign if_elig = bus.IF_REQ && !bus.FLUSH;

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_if = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_elig || bus.DM_REQ) begin
                    grant    = 1'b1;
                    grant_if = pick_if(if_elig, bus.DM_REQ, starve_sat);
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.M_READY) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Only DM grants that actually pass over a live fetch count toward starvation.
    assign starve_inc = grant && !grant_if && if_elig;
    assign starve_clr = (grant && grant_if) || !bus.IF_REQ;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_starve (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .cnt   (starve_cnt),
        .sat   (starve_sat)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Command capture at grant; held stable through ISSUE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner     <= OWN_IF;
            m_we_q    <= 1'b0;
            m_size_q  <= SZ_B;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else if (grant) begin
            if (grant_if) begin
                owner     <= OWN_IF;
                m_we_q    <= 1'b0;
                m_size_q  <= SZ_W;
                m_addr_q  <= bus.IF_ADDR;
                m_wdata_q <= '0;
            end else begin
                owner     <= OWN_DM;
                m_we_q    <= bus.DM_WE;
                m_size_q  <= bus.DM_SIZE;
                m_addr_q  <= bus.DM_ADDR;
                m_wdata_q <= bus.DM_WDATA;
            end
        end
    end

    // A flushed fetch still has to wait out the memory, so remember to drop its result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if_kill <= 1'b0;
        end else if (grant) begin
            if_kill <= 1'b0;
        end else if (state == ST_ISSUE && owner == OWN_IF && bus.FLUSH) begin
            if_kill <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (state == ST_ISSUE && bus.M_READY) begin
            if (owner == OWN_DM) begin
                dm_rdata_q <= bus.M_RDATA;
            end else if (!if_kill && !bus.FLUSH) begin
                if_rdata_q <= bus.M_RDATA[31:0];
            end
        end
    end

    assign bus.M_REQ    = (state == ST_ISSUE);
    assign bus.M_WE     = m_we_q;
    assign bus.M_SIZE   = m_size_q;
    assign bus.M_ADDR   = m_addr_q;
    assign bus.M_WDATA  = m_wdata_q;

    assign bus.IF_RDATA = if_rdata_q;
    assign bus.DM_RDATA = dm_rdata_q;
    assign bus.IF_DONE  = (state == ST_RESP) && (owner == OWN_IF) && !if_kill && !RESET;
    assign bus.DM_DONE  = (state == ST_RESP) && (owner == OWN_DM) && !RESET;
    assign bus.IF_STALL = bus.IF_REQ && !bus.IF_DONE;
    assign bus.DM_STALL = bus.DM_REQ && !bus.DM_DONE;
    assign bus.BUSY     = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written corner sequences.
module tb_mem_port_arbiter;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (2)
    ) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic        ifq;
        logic [63:0] ifa;
        logic        fl;
        logic        dmq;
        logic        dwe;
        logic [1:0]  dsz;
        logic [63:0] dma;
        logic [63:0] dwd;
        logic [63:0] mrd;
        logic        mrdy;
        logic        e_mreq;
        logic        e_mwe;
        logic [1:0]  e_msz;
        logic [63:0] e_maddr;
        logic [63:0] e_mwd;
        logic        e_ifd;
        logic [31:0] e_ifrd;
        logic        e_dmd;
        logic [63:0] e_dmrd;
        logic        e_busy;
        logic        e_ifst;
        logic        e_dmst;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(
        input logic ifq, input logic [63:0] ifa, input logic fl,
        input logic dmq, input logic dwe, input logic [1:0] dsz, input logic [63:0] dma, input logic [63:0] dwd,
        input logic [63:0] mrd, input logic mrdy,
        input logic e_mreq, input logic e_mwe, input logic [1:0] e_msz, input logic [63:0] e_maddr, input logic [63:0] e_mwd,
        input logic e_ifd, input logic [31:0] e_ifrd, input logic e_dmd, input logic [63:0] e_dmrd,
        input logic e_busy, input logic e_ifst, input logic e_dmst);
        vec_t v;
        v.ifq = ifq; v.ifa = ifa; v.fl = fl;
        v.dmq = dmq; v.dwe = dwe; v.dsz = dsz; v.dma = dma; v.dwd = dwd;
        v.mrd = mrd; v.mrdy = mrdy;
        v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_msz = e_msz; v.e_maddr = e_maddr; v.e_mwd = e_mwd;
        v.e_ifd = e_ifd; v.e_ifrd = e_ifrd; v.e_dmd = e_dmd; v.e_dmrd = e_dmrd;
        v.e_busy = e_busy; v.e_ifst = e_ifst; v.e_dmst = e_dmst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before the caller checks.
    task automatic drive(input logic rst, input logic ifq, input logic [63:0] ifa, input logic fl,
                         input logic dmq, input logic dwe, input logic [1:0] dsz,
                         input logic [63:0] dma, input logic [63:0] dwd,
                         input logic [63:0] mrd, input logic mrdy);
        @(negedge CLK);
        RESET        = rst;
        bus.IF_REQ   = ifq;
        bus.IF_ADDR  = ifa;
        bus.FLUSH    = fl;
        bus.DM_REQ   = dmq;
        bus.DM_WE    = dwe;
        bus.DM_SIZE  = dsz;
        bus.DM_ADDR  = dma;
        bus.DM_WDATA = dwd;
        bus.M_RDATA  = mrd;
        bus.M_READY  = mrdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] D1 = 64'hCAFEF00D_12345678;
    localparam logic [63:0] DL = 64'h11112222_33334444;
    localparam logic [63:0] DI = 64'hAAAABBBB_00000042;
    localparam logic [31:0] R1 = 32'h12345678;

    initial begin
        // Lone fetch at 0x1000, ready three cycles after M_REQ.
        tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 2, 'h1000, 0, 0, 0,  0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 2, 'h1000, 0, 0, 0,  0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 2, 'h1000, 0, 0, 0,  0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 0, D1, 1, 1, 0, 2, 'h1000, 0, 0, 0,  0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 'h1000, 0, 1, R1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 'h1000, 0, 0, R1, 0, 0, 0, 0, 0));
        // DM halfword store to 0x2002, ready in the first ISSUE cycle.
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 'h2002, 'hBEEF, 0,     0, 0, 0, 2, 'h1000, 0,       0, R1, 0, 0,     0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 'h2002, 'hBEEF, 'h55,  1, 1, 1, 1, 'h2002, 'hBEEF,  0, R1, 0, 0,     1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 'h2002, 'hBEEF, 0,     0, 0, 1, 1, 'h2002, 'hBEEF,  0, R1, 1, 'h55,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,      0,      0,     0, 0, 1, 1, 'h2002, 'hBEEF,  0, R1, 0, 'h55,  0, 0, 0));
        // IF and DM load rise together: DM first, IF in the idle cycle after DM's RESP.
        tbl.push_back(mk(1, 'h1004, 0, 1, 0, 3, 'h3000, 0, 0,  0, 0, 1, 1, 'h2002, 'hBEEF, 0, R1,    0, 'h55, 0, 1, 1));
        tbl.push_back(mk(1, 'h1004, 0, 1, 0, 3, 'h3000, 0, DL, 1, 1, 0, 3, 'h3000, 0,      0, R1,    0, 'h55, 1, 1, 1));
        tbl.push_back(mk(1, 'h1004, 0, 1, 0, 3, 'h3000, 0, 0,  0, 0, 0, 3, 'h3000, 0,      0, R1,    1, DL,   1, 1, 0));
        tbl.push_back(mk(1, 'h1004, 0, 0, 0, 0, 0,      0, 0,  0, 0, 0, 3, 'h3000, 0,      0, R1,    0, DL,   0, 1, 0));
        tbl.push_back(mk(1, 'h1004, 0, 0, 0, 0, 0,      0, DI, 1, 1, 0, 2, 'h1004, 0,      0, R1,    0, DL,   1, 1, 0));
        tbl.push_back(mk(1, 'h1004, 0, 0, 0, 0, 0,      0, 0,  0, 0, 0, 2, 'h1004, 0,      1, 'h42,  0, DL,   1, 0, 0));
        // Stray M_READY while idle must not start anything or touch read data.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 2, 'h1004, 0, 0, 'h42, 0, DL, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 2, 'h1004, 0, 0, 'h42, 0, DL, 0, 0, 0));

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("reset.M_REQ",    64'(bus.M_REQ),    0);
        chk("reset.M_WE",     64'(bus.M_WE),     0);
        chk("reset.M_SIZE",   64'(bus.M_SIZE),   0);
        chk("reset.M_ADDR",   bus.M_ADDR,        0);
        chk("reset.M_WDATA",  bus.M_WDATA,       0);
        chk("reset.IF_DONE",  64'(bus.IF_DONE),  0);
        chk("reset.DM_DONE",  64'(bus.DM_DONE),  0);
        chk("reset.IF_RDATA", 64'(bus.IF_RDATA), 0);
        chk("reset.DM_RDATA", bus.DM_RDATA,      0);
        chk("reset.BUSY",     64'(bus.BUSY),     0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive(0, v.ifq, v.ifa, v.fl, v.dmq, v.dwe, v.dsz, v.dma, v.dwd, v.mrd, v.mrdy);
            chk($sformatf("row%0d.M_REQ", i),    64'(bus.M_REQ),    64'(v.e_mreq));
            chk($sformatf("row%0d.M_WE", i),     64'(bus.M_WE),     64'(v.e_mwe));
            chk($sformatf("row%0d.M_SIZE", i),   64'(bus.M_SIZE),   64'(v.e_msz));
            chk($sformatf("row%0d.M_ADDR", i),   bus.M_ADDR,        v.e_maddr);
            chk($sformatf("row%0d.M_WDATA", i),  bus.M_WDATA,       v.e_mwd);
            chk($sformatf("row%0d.IF_DONE", i),  64'(bus.IF_DONE),  64'(v.e_ifd));
            chk($sformatf("row%0d.IF_RDATA", i), 64'(bus.IF_RDATA), 64'(v.e_ifrd));
            chk($sformatf("row%0d.DM_DONE", i),  64'(bus.DM_DONE),  64'(v.e_dmd));
            chk($sformatf("row%0d.DM_RDATA", i), bus.DM_RDATA,      v.e_dmrd);
            chk($sformatf("row%0d.BUSY", i),     64'(bus.BUSY),     64'(v.e_busy));
            chk($sformatf("row%0d.IF_STALL", i), 64'(bus.IF_STALL), 64'(v.e_ifst));
            chk($sformatf("row%0d.DM_STALL", i), 64'(bus.DM_STALL), 64'(v.e_dmst));
        end

        // Starvation with STARVE_MAX = 2: two DM grants, then IF, then count back to 0.
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 0, 0);
        chk("starve.idle0.BUSY", 64'(bus.BUSY), 0);
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 64'h61, 1);
        chk("starve.grant1.M_ADDR", bus.M_ADDR, 'h6000);
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 0, 0);
        chk("starve.resp1.DM_DONE", 64'(bus.DM_DONE), 1);
        chk("starve.resp1.IF_DONE", 64'(bus.IF_DONE), 0);
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 0, 0);
        chk("starve.idle1.BUSY", 64'(bus.BUSY), 0);
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 64'h62, 1);
        chk("starve.grant2.M_ADDR", bus.M_ADDR, 'h6000);
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 0, 0);
        chk("starve.resp2.DM_DONE", 64'(bus.DM_DONE), 1);
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 0, 0);
        chk("starve.idle2.count", 64'(u_dut.starve_cnt), 2);
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 64'h77, 1);
        chk("starve.grant3.M_ADDR", bus.M_ADDR, 'h5000);
        chk("starve.grant3.M_SIZE", 64'(bus.M_SIZE), 2);
        chk("starve.grant3.count", 64'(u_dut.starve_cnt), 0);
        drive(0, 1, 'h5000, 0, 1, 0, 3, 'h6000, 0, 0, 0);
        chk("starve.resp3.IF_DONE", 64'(bus.IF_DONE), 1);
        chk("starve.resp3.IF_RDATA", 64'(bus.IF_RDATA), 'h77);
        chk("starve.resp3.DM_STALL", 64'(bus.DM_STALL), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("starve.end.BUSY", 64'(bus.BUSY), 0);

        // Flush while IF is in ISSUE; memory answers two cycles later.
        drive(0, 1, 'h7000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush.idle.BUSY", 64'(bus.BUSY), 0);
        drive(0, 1, 'h7000, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("flush.issue.M_REQ", 64'(bus.M_REQ), 1);
        chk("flush.issue.M_ADDR", bus.M_ADDR, 'h7000);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush.wait.M_REQ", 64'(bus.M_REQ), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h99, 1);
        chk("flush.ready.M_REQ", 64'(bus.M_REQ), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush.resp.IF_DONE", 64'(bus.IF_DONE), 0);
        chk("flush.resp.BUSY", 64'(bus.BUSY), 1);
        chk("flush.resp.IF_RDATA", 64'(bus.IF_RDATA), 'h77);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush.after.BUSY", 64'(bus.BUSY), 0);
        chk("flush.after.IF_RDATA", 64'(bus.IF_RDATA), 'h77);

        // Flush in IDLE blocks IF that cycle; the following fetch completes normally.
        drive(0, 1, 'h8000, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("flidle.IF_STALL", 64'(bus.IF_STALL), 1);
        drive(0, 1, 'h8000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flidle.still_idle.BUSY", 64'(bus.BUSY), 0);
        drive(0, 1, 'h8000, 0, 0, 0, 0, 0, 0, 64'h88, 1);
        chk("flidle.issue.M_ADDR", bus.M_ADDR, 'h8000);
        chk("flidle.issue.M_REQ", 64'(bus.M_REQ), 1);
        drive(0, 1, 'h8000, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flidle.resp.IF_DONE", 64'(bus.IF_DONE), 1);
        chk("flidle.resp.IF_RDATA", 64'(bus.IF_RDATA), 'h88);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flidle.end.BUSY", 64'(bus.BUSY), 0);

        // Reset during ISSUE, memory answers the next cycle.
        drive(0, 0, 0, 0, 1, 0, 2, 'h9000, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 2, 'h9000, 0, 0, 0);
        chk("rstiss.issue.M_REQ", 64'(bus.M_REQ), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'hDD, 1);
        chk("rstiss.M_REQ", 64'(bus.M_REQ), 0);
        chk("rstiss.BUSY", 64'(bus.BUSY), 0);
        chk("rstiss.DM_DONE", 64'(bus.DM_DONE), 0);
        chk("rstiss.M_ADDR", bus.M_ADDR, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstiss.late.DM_DONE", 64'(bus.DM_DONE), 0);
        chk("rstiss.late.BUSY", 64'(bus.BUSY), 0);
        chk("rstiss.late.DM_RDATA", bus.DM_RDATA, 0);
        drive(0, 0, 0, 0, 1, 0, 3, 'hA000, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 3, 'hA000, 0, 64'hEE, 1);
        chk("rstiss.next.M_REQ", 64'(bus.M_REQ), 1);
        chk("rstiss.next.M_ADDR", bus.M_ADDR, 'hA000);
        chk("rstiss.next.M_SIZE", 64'(bus.M_SIZE), 3);
        drive(0, 0, 0, 0, 1, 0, 3, 'hA000, 0, 0, 0);
        chk("rstiss.next.DM_DONE", 64'(bus.DM_DONE), 1);
        chk("rstiss.next.DM_RDATA", bus.DM_RDATA, 'hEE);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstiss.end.BUSY", 64'(bus.BUSY), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
